// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter (arb_rrb) and its priority encoder.
package arb_pkg;

    localparam int ARB_MAXW = 64;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Zero-extend narrower vectors into the ARB_MAXW-wide arguments.
    function automatic logic [5:0] oht2bin(input logic [ARB_MAXW-1:0] vec);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < ARB_MAXW; i++) begin
            if (vec[i]) r = r | 6'(i);
        end
        return r;
    endfunction

    function automatic logic [ARB_MAXW-1:0] clr_le(input logic [ARB_MAXW-1:0] vec,
                                                   input logic [31:0]         ptr);
        logic [ARB_MAXW-1:0] r;
        r = vec;
        for (int i = 0; i < ARB_MAXW; i++) begin
            if (32'(i) <= ptr) r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pri_oht.sv
// Lowest-index-first priority encoder: one-hot of the lowest set bit plus an any-set flag.
// IMPLEMENTATION 0 scans linearly; 1 picks a SPLIT-wide group first, then a bit inside it.
module pri_oht #(
    parameter int WIDTH          = 16,
    parameter int SPLIT          = 4,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] oht,
    output logic             any
);

    assign any = |req;

    generate
        if (IMPLEMENTATION == 0) begin : g_lin
            always_comb begin
                oht = '0;
                for (int i = WIDTH-1; i >= 0; i--) begin
                    if (req[i]) begin
                        oht    = '0;
                        oht[i] = 1'b1;
                    end
                end
            end
        end else begin : g_tree
            localparam int NGRP = (WIDTH + SPLIT - 1) / SPLIT;
            localparam int PADW = NGRP * SPLIT;

            logic [PADW-1:0] pad;
            logic [PADW-1:0] sel;
            logic [NGRP-1:0] grp_any;
            logic [NGRP-1:0] grp_sel;

            assign pad = PADW'(req);

            always_comb begin
                grp_any = '0;
                grp_sel = '0;
                sel     = '0;
                for (int g = 0; g < NGRP; g++) begin
                    grp_any[g] = |pad[g*SPLIT +: SPLIT];
                end
                for (int g = NGRP-1; g >= 0; g--) begin
                    if (grp_any[g]) begin
                        grp_sel    = '0;
                        grp_sel[g] = 1'b1;
                    end
                end
                for (int g = 0; g < NGRP; g++) begin
                    for (int j = SPLIT-1; j >= 0; j--) begin
                        if (grp_sel[g] && pad[g*SPLIT + j]) begin
                            sel[g*SPLIT +: SPLIT]  = '0;
                            sel[g*SPLIT + j]       = 1'b1;
                        end
                    end
                end
            end

            assign oht = sel[WIDTH-1:0];
        end
    endgenerate

endmodule

// File: rtl/arb_rrb.sv
// Round-robin arbiter feeding mux_oht with a one-hot grant; define ARB_RRB_LOCK_EN to hold
// the grant across multi-beat packets (req_lst), otherwise priority rotates on every beat.
module arb_rrb
    import arb_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int SPLIT          = 4,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req_vld,
    input  logic [WIDTH-1:0]         req_lst,
    output logic [WIDTH-1:0]         req_rdy,
    output logic [WIDTH-1:0]         oht,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     vld,
    output logic                     lst,
    input  logic                     rdy
);

    localparam int IW = $clog2(WIDTH);

    logic [IW-1:0]    ptr;
    logic [WIDTH-1:0] msk;
    logic [WIDTH-1:0] msk_oht;
    logic [WIDTH-1:0] vld_oht;
    logic             msk_any;
    logic             vld_any;
    logic [WIDTH-1:0] arb_oht;
    logic [WIDTH-1:0] gnt_oht;
    logic [IW-1:0]    gnt_idx;
    logic             xfr;

    assign msk = WIDTH'(clr_le(ARB_MAXW'(req_vld), 32'(ptr)));

    pri_oht #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_pri_msk (
        .req (msk),
        .oht (msk_oht),
        .any (msk_any)
    );

    pri_oht #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_pri_vld (
        .req (req_vld),
        .oht (vld_oht),
        .any (vld_any)
    );

    // Requests above ptr win; otherwise wrap around to the lowest requestor.
    assign arb_oht = msk_any ? msk_oht : (vld_any ? vld_oht : '0);

`ifdef ARB_RRB_LOCK_EN
    arb_state_t       state;
    logic [WIDTH-1:0] lck_oht;

    assign gnt_oht = (state == LOCK) ? lck_oht : arb_oht;
`else
    assign gnt_oht = arb_oht;
`endif

    assign gnt_idx = IW'(oht2bin(ARB_MAXW'(gnt_oht)));

    assign oht     = rst_n ? gnt_oht : '0;
    assign idx     = rst_n ? gnt_idx : '0;
    assign vld     = rst_n & (|(gnt_oht & req_vld));
    assign lst     = rst_n & (|(gnt_oht & req_lst));
    assign req_rdy = rst_n ? (gnt_oht & {WIDTH{rdy}}) : '0;
    assign xfr     = vld & rdy;

`ifdef ARB_RRB_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= IW'(WIDTH-1);
            state   <= ARB;
            lck_oht <= '0;
        end else if (xfr) begin
            if (lst) begin
                state <= ARB;
                ptr   <= gnt_idx;
            end else if (state == ARB) begin
                state   <= LOCK;
                lck_oht <= gnt_oht;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= IW'(WIDTH-1);
        end else if (xfr) begin
            ptr <= gnt_idx;
        end
    end
`endif

endmodule
